// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: packetising write-side producer for the async FIFO (optional padding via WCTRL_PAD_EN)
module fifo_write_ctrl #(
    parameter int         PKT_LEN  = 64,
    parameter logic [7:0] PAD_BYTE = 8'h00,
    parameter int         CNT_W    = 8
) (
    input  logic             w_clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             full,
    output logic             w_en,
    output logic [7:0]       w_data,
    output logic             pkt_done,
    output logic [CNT_W-1:0] pkt_count,
    output logic             busy
);
    localparam int BW = $clog2(PKT_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
`ifdef WCTRL_PAD_EN
    localparam bit PAD_EN = 1'b1;
    typedef enum logic [1:0] {IDLE, STREAM, PAD} state_t;
`else
    localparam bit PAD_EN = 1'b0;
    typedef enum logic [0:0] {IDLE, STREAM} state_t;
`endif

    state_t           state_q, state_d;
    logic             hold_valid_q, hold_valid_d;
    logic [7:0]       hold_data_q, hold_data_d;
    logic             hold_last_q, hold_last_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic             pkt_done_q, pkt_done_d;
    logic             in_pad, accept, last_wr, wrap, short_end;

    // write strobe, hold register handshake and packet beat accounting
    always_comb begin
        in_pad = 1'b0;
`ifdef WCTRL_PAD_EN
        in_pad = state_q == PAD;
`endif
        w_en = in_pad ? !full : hold_valid_q & !full;
        w_data = in_pad ? PAD_BYTE : hold_data_q;
        in_ready = !in_pad & (!hold_valid_q | w_en);
        accept = in_valid & in_ready;
        last_wr = w_en & !in_pad & hold_last_q;
        wrap = w_en & (beat_q == LAST_BEAT);
        short_end = last_wr & !wrap;
        pkt_done_d = wrap | (short_end & !PAD_EN);
        beat_d = !w_en ? beat_q : pkt_done_d ? '0 : beat_q + BW'(1);
        hold_valid_d = accept | (hold_valid_q & !(w_en & !in_pad));
        hold_data_d = accept ? in_data : hold_data_q;
        hold_last_d = accept ? in_last : hold_last_q;
        pkt_count_d = pkt_count_q + CNT_W'(pkt_done_d);
        busy = hold_valid_q | (state_q != IDLE);
    end

    // frame FSM: a short frame end either pads out the packet or closes it early
    always_comb begin
        state_d = state_q;
        if (in_pad) begin
            if (wrap) state_d = IDLE;
        end
`ifdef WCTRL_PAD_EN
        else if (short_end) state_d = PAD;
`endif
        else if (last_wr) state_d = accept ? STREAM : IDLE;
        else if (accept | hold_valid_q) state_d = STREAM;
    end

    // state and datapath registers; reset discards any held byte or pad in progress
    always_ff @(posedge w_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'h00;
            hold_last_q  <= 1'b0;
            beat_q       <= '0;
            pkt_count_q  <= '0;
            pkt_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            beat_q       <= beat_d;
            pkt_count_q  <= pkt_count_d;
            pkt_done_q   <= pkt_done_d;
        end
    end

    assign pkt_done  = pkt_done_q;
    assign pkt_count = pkt_count_q;
endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb_fifo_write_ctrl: directed and random stimulus checked against a transaction-level model
module tb_fifo_write_ctrl;
    localparam int PKT_LEN = 64;
    localparam logic [7:0] PAD_BYTE = 8'h00;
`ifdef WCTRL_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic       w_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       full = 1'b0;
    logic       in_ready, w_en, pkt_done, busy;
    logic [7:0] w_data, pkt_count;

    fifo_write_ctrl #(.PKT_LEN(PKT_LEN), .PAD_BYTE(PAD_BYTE), .CNT_W(8)) dut (
        .w_clk(w_clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .full(full), .w_en(w_en), .w_data(w_data),
        .pkt_done(pkt_done), .pkt_count(pkt_count), .busy(busy)
    );

    always #5 w_clk = ~w_clk;

    int total = 0;
    int bad = 0;

    logic [8:0] hq[$];
    int         beats = 0;
    int         pad_left = 0;
    bit         open = 0;
    bit         exp_done = 0;
    logic [7:0] cnt = 8'h00;
    bit         acc;
    int         writes = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        beats = 0;
        pad_left = 0;
        open = 0;
        exp_done = 0;
        cnt = 8'h00;
    endtask

    task automatic cyc(input bit r, input bit v, input logic [7:0] d, input bit l, input bit f);
        bit ew, er, done;
        logic [7:0] ed;
        logic [8:0] e;
        rst = r; in_valid = v; in_data = d; in_last = l; full = f;
        #1;
        ew = pad_left > 0 ? !f : (hq.size() > 0 && !f);
        ed = pad_left > 0 ? PAD_BYTE : (hq.size() > 0 ? hq[0][7:0] : 8'h00);
        er = pad_left == 0 && (hq.size() == 0 || ew);
        chk("w_en", w_en, ew);
        chk("in_ready", in_ready, er);
        if (ew) chk("w_data", w_data, ed);
        chk("pkt_done", pkt_done, exp_done);
        chk("pkt_count", pkt_count, cnt);
        chk("busy", busy, hq.size() > 0 || pad_left > 0 || open);
        acc = v && er;
        if (r) model_reset();
        else begin
            done = 0;
            if (ew) begin
                writes++;
                beats++;
                if (pad_left > 0) pad_left--;
                else begin
                    e = hq.pop_front();
                    if (e[8]) begin
                        open = 0;
                        if (beats < PKT_LEN) begin
                            if (PAD_EN) pad_left = PKT_LEN - beats;
                            else begin done = 1; beats = 0; end
                        end
                    end
                end
                if (beats == PKT_LEN) begin done = 1; beats = 0; end
            end
            if (acc) begin hq.push_back({l, d}); open = 1; end
            exp_done = done;
            cnt = cnt + 8'(done);
        end
        @(negedge w_clk);
    endtask

    task automatic push(input logic [7:0] d, input bit l, input bit f);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            cyc(0, 1, d, l, f);
            got = acc;
        end
        chk("push_timeout", got, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0, 0);
    endtask

    task automatic frame(input int n, input int last_at);
        for (int i = 0; i < n; i++) push(8'(i), i == last_at, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 1; in_data = 8'hA5;
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        #1;
        chk("rst_w_en", w_en, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_w_data", w_data, 0);
        model_reset();
        rst = 0; in_valid = 0;

        writes = 0;
        frame(64, 63);
        idle(4);
        chk("stream_writes", writes, 64);
        chk("stream_count", pkt_count, 1);

        for (int i = 0; i < 12; i++) push(8'(i), 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'd12, 0, 1);
        for (int i = 12; i < 64; i++) push(8'(i), i == 63, 0);
        idle(4);
        chk("bp_count", pkt_count, 2);

        writes = 0;
        frame(10, 9);
        idle(70);
        chk("short_writes", writes, PAD_EN ? 64 : 10);
        chk("short_count", pkt_count, 3);
        chk("short_idle", busy, 0);
        frame(64, 63);
        idle(4);
        chk("after_short_count", pkt_count, 4);

        frame(10, 9);
        idle(5);
        cyc(1, 0, 8'h00, 0, 0);
        writes = 0;
        idle(60);
        chk("midpad_no_writes", writes, 0);
        chk("midpad_count", pkt_count, 0);

        for (int p = 0; p < 256; p++) begin
            frame(64, 63);
            if (p == 254) begin idle(3); chk("count_255", pkt_count, 255); end
        end
        idle(3);
        chk("count_wrap", pkt_count, 0);

        for (int i = 0; i < 3000; i++)
            cyc(0, ($urandom % 4) != 0, 8'($urandom), ($urandom % 16) == 0, ($urandom % 4) == 0);
        idle(80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
